// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: round-robin 4:1 W-bit mux feeding a one-word output slot.
// Ports: clk, rst (sync, active-high), in_valid/in_ready[3:0], in_data0..3,
//        out_valid/out_ready, out_data (registered winner), out_src (its index).
module rr_mux4_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_src
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [1:0]   out_src_q, out_src_d;
  logic [1:0]   ptr_q, ptr_d;

  logic         load_ok;
  logic         gnt_hit;
  logic [1:0]   gnt_idx;
  logic [1:0]   scan_idx;
  logic [W-1:0] sel_data;

  // Slot can take a word when empty or being drained this cycle.
  assign load_ok = !out_valid_q || out_ready;

  // Scan ptr, ptr+1, ptr+2, ptr+3; first valid index wins.
  always_comb begin
    gnt_hit  = 1'b0;
    gnt_idx  = 2'd0;
    scan_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!gnt_hit && in_valid[scan_idx]) begin
        gnt_hit = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (rst || !load_ok) begin
      gnt_hit = 1'b0;
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (gnt_hit) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Only the granted word is selected, so junk on others never loads.
  always_comb begin
    sel_data = '0;
    unique case (gnt_idx)
      2'd0: sel_data = in_data0;
      2'd1: sel_data = in_data1;
      2'd2: sel_data = in_data2;
      2'd3: sel_data = in_data3;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (gnt_hit) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = gnt_idx;
      ptr_d       = gnt_idx + 2'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      ptr_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb_rr_mux4_arbiter: directed self-checking bench for rr_mux4_arbiter.
// One task per scenario; inline comparisons; summary line at the end.
module tb_rr_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_src;

  int total = 0;
  int bad   = 0;

  rr_mux4_arbiter #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 4'hF;
    out_ready = 1'b1;
    in_data0 = 4'hA; in_data1 = 4'hB;
    in_data2 = 4'hC; in_data3 = 4'hD;
    step();
    step();
    total++;
    if (in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=0000", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (out_data !== 4'h0) begin
      bad++;
      $display("FAIL reset_out_data got=%h want=0", out_data);
    end
    total++;
    if (out_src !== 2'd0) begin
      bad++;
      $display("FAIL reset_out_src got=%0d want=0", out_src);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_d [5];
    logic [1:0] exp_s [5];
    exp_d = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b0;
    in_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rr_first_grant got=%b want=0001", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i]
          || out_src !== exp_s[i]) begin
        bad++;
        $display("FAIL rr_seq%0d got=%b/%h/%0d want=1/%h/%0d",
                 i, out_valid, out_data, out_src, exp_d[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 4'hF;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    total++;
    if (in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL stall_in_ready0 got=%b want=0000", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'hA
          || out_src !== 2'd0 || in_ready !== 4'b0000) begin
        bad++;
        $display("FAIL stall_hold%0d got=%b/%h/%0d/%b want=1/a/0/0000",
                 i, out_valid, out_data, out_src, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0010) begin
      bad++;
      $display("FAIL stall_resume_grant got=%b want=0010", in_ready);
    end
    step();
    total++;
    if (out_data !== 4'hB || out_src !== 2'd1) begin
      bad++;
      $display("FAIL stall_next got=%h/%0d want=b/1",
               out_data, out_src);
    end
  endtask

  task automatic test_idle_drain();
    do_reset();
    in_valid = 4'hF;
    out_ready = 1'b1;
    step();
    in_valid = 4'h0;
    step();
    total++;
    if (out_valid !== 1'b0 || out_data !== 4'hA
        || out_src !== 2'd0) begin
      bad++;
      $display("FAIL drain got=%b/%h/%0d want=0/a/0",
               out_valid, out_data, out_src);
    end
    step();
    in_valid = 4'hF;
    #1;
    total++;
    if (in_ready !== 4'b0010) begin
      bad++;
      $display("FAIL idle_ptr_hold got=%b want=0010", in_ready);
    end
  endtask

  task automatic test_sparse_wrap();
    logic [3:0] exp_r [3];
    logic [1:0] exp_s [3];
    logic [3:0] exp_d [3];
    exp_r = '{4'b0001, 4'b0010, 4'b0001};
    exp_s = '{2'd0, 2'd1, 2'd0};
    exp_d = '{4'hA, 4'hB, 4'hA};
    do_reset();
    in_valid = 4'b0100;
    out_ready = 1'b1;
    step();
    total++;
    if (out_src !== 2'd2 || out_data !== 4'hC) begin
      bad++;
      $display("FAIL sparse_setup got=%0d/%h want=2/c",
               out_src, out_data);
    end
    in_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== exp_r[i]) begin
        bad++;
        $display("FAIL sparse_grant%0d got=%b want=%b",
                 i, in_ready, exp_r[i]);
      end
      step();
      total++;
      if (out_src !== exp_s[i] || out_data !== exp_d[i]) begin
        bad++;
        $display("FAIL sparse_out%0d got=%0d/%h want=%0d/%h",
                 i, out_src, out_data, exp_s[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_x_isolation();
    logic [3:0] exp_d [4];
    exp_d = '{4'd7, 4'd10, 4'd3, 4'd7};
    do_reset();
    in_data0 = 4'd7; in_data1 = 4'd10;
    in_data2 = 4'd3; in_data3 = 4'bxxxx;
    in_valid = 4'b0111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ($isunknown(out_data) || out_data !== exp_d[i]) begin
        bad++;
        $display("FAIL xiso%0d got=%h want=%h",
                 i, out_data, exp_d[i]);
      end
    end
    in_data0 = 4'hA; in_data1 = 4'hB;
    in_data2 = 4'hC; in_data3 = 4'hD;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 4'hF;
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_in_ready got=%b want=0000", in_ready);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || out_data !== 4'h0
        || out_src !== 2'd0) begin
      bad++;
      $display("FAIL midrst_state got=%b/%h/%0d want=0/0/0",
               out_valid, out_data, out_src);
    end
    rst = 1'b0;
    in_valid = 4'b0110;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0010) begin
      bad++;
      $display("FAIL midrst_grant got=%b want=0010", in_ready);
    end
    step();
    total++;
    if (out_src !== 2'd1 || out_data !== 4'hB) begin
      bad++;
      $display("FAIL midrst_out got=%0d/%h want=1/b",
               out_src, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_idle_drain();
    test_sparse_wrap();
    test_x_isolation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
